module_keypad_scanner: RTL

//  Drive side of the 4x4 matrix keypad. Walks a one-hot active-low column strobe, samples the row lines,

---
 rtl/keypad_pkg.sv | 38 +++
 rtl/module_keypad_scanner_tick_gen.sv | 30 +++
 rtl/module_keypad_scanner.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
// Scanner states, default timing and row decoding.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    CONFIRM,
    HOLD
  } kp_state_t;

  localparam int DEF_SCAN_DIV   = 27000;
  localparam int DEF_STABLE_CNT = 5;
  localparam int OH_MAX         = 32;

  typedef struct packed {
    logic       single;
    logic [4:0] idx;
  } onehot_t;

  // Position of the low bit and whether exactly one bit is low.
  function automatic onehot_t encode_onehot_low(
    input logic [OH_MAX-1:0] v
  );
    onehot_t r;
    int      zeros;
    r     = '0;
    zeros = 0;
    for (int i = 0; i < OH_MAX; i++) begin
      if (!v[i]) begin
        zeros++;
        r.idx = 5'(i);
      end
    end
    r.single = (zeros == 1);
    return r;
  endfunction

endpackage

// File: rtl/module_keypad_scanner_tick_gen.sv
// Free-running scan tick divider.
// tick_o is high for one clk every SCAN_DIV clks.
module module_tick_gen #(
  parameter int SCAN_DIV = 27000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);

  logic [W-1:0] div_q;
  logic [W-1:0] div_d;

  // Count 0..SCAN_DIV-1 and wrap.
  always_comb begin
    div_d = (div_q == LAST) ? '0 : div_q + 1'b1;
  end

  // Divider register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_q <= '0;
    else     div_q <= div_d;
  end

  assign tick_o = (div_q == LAST);

endmodule

// File: rtl/module_keypad_scanner.sv
// 4x4 matrix keypad scanner with press and release debounce.
// Emits a one-cycle key_valid with the encoded key.
module module_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int N_COLS     = 4,
  parameter int N_ROWS     = 4,
  parameter int SCAN_DIV   = DEF_SCAN_DIV,
  parameter int STABLE_CNT = DEF_STABLE_CNT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_ROWS-1:0]                 row_i,
  output logic [N_COLS-1:0]                 col_o,
  output logic [$clog2(N_ROWS*N_COLS)-1:0]  key_code,
  output logic                              key_valid,
  output logic                              key_held
);

  localparam int CW   = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int RW   = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int KW   = $clog2(N_ROWS * N_COLS);
  localparam int NW   = $clog2(STABLE_CNT + 1);
  localparam logic [NW-1:0] STABLE = NW'(STABLE_CNT);
  localparam logic [CW-1:0] COL_LAST = CW'(N_COLS - 1);

  logic              tick;
  logic [N_ROWS-1:0] sync1_q;
  logic [N_ROWS-1:0] rows_s_q;
  onehot_t           oh;
  logic              unused_oh;

  kp_state_t         state_q, state_d;
  logic [CW-1:0]     col_q, col_d, col_next;
  logic [RW-1:0]     row_idx_q, row_idx_d;
  logic [N_ROWS-1:0] pat_q, pat_d;
  logic [NW-1:0]     match_q, match_d, match_inc;
  logic [NW-1:0]     rel_q, rel_d, rel_inc;
  logic [KW-1:0]     code_q, code_d;
  logic              valid_q, valid_d;
  logic              held_q, held_d;

  module_tick_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .tick_o(tick)
  );

  // Two-flop synchronizer for the asynchronous row pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '1;
      rows_s_q <= '1;
    end else begin
      sync1_q  <= row_i;
      rows_s_q <= sync1_q;
    end
  end

  if (N_ROWS < OH_MAX) begin : g_pad
    assign oh = encode_onehot_low({{(OH_MAX-N_ROWS){1'b1}}, rows_s_q});
  end else begin : g_nopad
    assign oh = encode_onehot_low(rows_s_q);
  end

  assign unused_oh = ^oh.idx;

  assign col_next  = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
  assign match_inc = match_q + 1'b1;
  assign rel_inc   = rel_q + 1'b1;

  // Scanner next-state and output decisions, one step per tick.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_idx_d = row_idx_q;
    pat_d     = pat_q;
    match_d   = match_q;
    rel_d     = rel_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    held_d    = held_q;
    unique case (state_q)
      SCAN: begin
        if (tick) begin
          if (oh.single) begin
            row_idx_d = oh.idx[RW-1:0];
            pat_d     = rows_s_q;
            match_d   = NW'(1);
            state_d   = CONFIRM;
          end else begin
            col_d = col_next;
          end
        end
      end
      CONFIRM: begin
        if (tick) begin
          if (rows_s_q == pat_q) begin
            match_d = match_inc;
            if (match_inc == STABLE) begin
              valid_d = 1'b1;
              held_d  = 1'b1;
              code_d  = KW'(int'(row_idx_q) * N_COLS + int'(col_q));
              match_d = '0;
              state_d = HOLD;
            end
          end else begin
            match_d = '0;
            col_d   = col_next;
            state_d = SCAN;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          if (&rows_s_q) begin
            rel_d = rel_inc;
            if (rel_inc == STABLE) begin
              rel_d   = '0;
              held_d  = 1'b0;
              col_d   = col_next;
              state_d = SCAN;
            end
          end else begin
            rel_d = '0;
          end
        end
      end
      default: begin
        state_d = SCAN;
      end
    endcase
  end

  // Scanner state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SCAN;
      col_q     <= '0;
      row_idx_q <= '0;
      pat_q     <= '1;
      match_q   <= '0;
      rel_q     <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_idx_q <= row_idx_d;
      pat_q     <= pat_d;
      match_q   <= match_d;
      rel_q     <= rel_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
    end
  end

  assign col_o     = ~(N_COLS'(1) << col_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule
